// File: rtl/msg_schedule.sv
// msg_schedule: SHA-2 message schedule expander.
//
// Takes a padded message as 16 words per block on an AXI-Stream slave and
// streams the full W_t schedule (64 words for SHA-224/256, 80 words for
// SHA-384/512) to the compression unit, one word per cycle.
//
// Ports:
//   axi_aclk, axi_resetn  clock, asynchronous active-low reset
//   sha_type[1]           0 = 32-bit words / 64 rounds, 1 = 64-bit words / 80 rounds
//   s_axis_*              padded message words M_t (tlast on word 15 of final block)
//   m_axis_tdata          W_t (upper 32 bits zero in 32-bit mode)
//   m_axis_tvalid/tready  output handshake
//   m_axis_tlast          final W_t of the final block
//   m_axis_round          round index t of m_axis_tdata
//   err                   sticky: tlast seen on a word other than word 15
//
// state  | meaning
// -------+-------------------------------------------------------------
// LOAD   | t = 0..15, pass message words through and into the window
// EXPAND | t = 16..N-1, generate W_t from the 16-word window
//
// Internally the datapath is 64 bits wide; DATA_WIDTH is expected to be 64.

module msg_schedule #(
  parameter int DATA_WIDTH  = 64,
  parameter int ROUND_WIDTH = 7
) (
  input  logic                   axi_aclk,
  input  logic                   axi_resetn,
  input  logic [1:0]             sha_type,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [ROUND_WIDTH-1:0] m_axis_round,
  output logic                   err
);

  typedef enum logic {LOAD, EXPAND} state_t;

  localparam logic [ROUND_WIDTH-1:0] T_ZERO     = ROUND_WIDTH'(0);
  localparam logic [ROUND_WIDTH-1:0] T_LOAD_END = ROUND_WIDTH'(15);
  localparam logic [ROUND_WIDTH-1:0] T_END_32   = ROUND_WIDTH'(63);
  localparam logic [ROUND_WIDTH-1:0] T_END_64   = ROUND_WIDTH'(79);

  function automatic logic [31:0] sig0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] sig0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  state_t                 state;
  logic [ROUND_WIDTH-1:0] t;
  logic [63:0]            win [16];   // win[15] = W[t-1] ... win[0] = W[t-16]
  logic                   mode64;
  logic                   first_blk;  // next block starts a new message
  logic                   last_blk;
  logic                   rdy_en;     // keeps s_axis_tready low through reset

  logic                   out_free;
  logic                   accept;
  logic                   mode_cur;
  logic                   advance;
  logic [ROUND_WIDTH-1:0] t_end;
  logic [63:0]            in_word;
  logic [63:0]            exp_word;
  logic [63:0]            nxt_word;
  logic [31:0]            exp_lo;
  logic                   unused_bits;

  assign unused_bits = sha_type[0];

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = rdy_en && (state == LOAD) && out_free;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Word 0 of a new message is masked with the mode being latched on that
  // same edge; every later word uses the latched mode.
  assign mode_cur = (first_blk && (t == T_ZERO)) ? sha_type[1] : mode64;
  assign t_end    = mode64 ? T_END_64 : T_END_32;

  assign in_word = mode_cur ? s_axis_tdata : {32'h0, s_axis_tdata[31:0]};

  assign exp_lo = sig1_32(win[14][31:0]) + win[9][31:0]
                + sig0_32(win[1][31:0]) + win[0][31:0];

  assign exp_word = mode64 ? (sig1_64(win[14]) + win[9] + sig0_64(win[1]) + win[0])
                           : {32'h0, exp_lo};

  assign nxt_word = (state == LOAD) ? in_word : exp_word;
  assign advance  = (state == LOAD) ? accept : out_free;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state         <= LOAD;
      t             <= T_ZERO;
      for (int i = 0; i < 16; i++) win[i] <= '0;
      mode64        <= 1'b0;
      first_blk     <= 1'b1;
      last_blk      <= 1'b0;
      rdy_en        <= 1'b0;
      err           <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_round  <= '0;
    end else begin
      rdy_en <= 1'b1;

      // A stray tlast is flagged but otherwise ignored.
      if (accept && s_axis_tlast && (t != T_LOAD_END)) err <= 1'b1;

      if (advance) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15]       <= nxt_word;
        m_axis_tdata  <= nxt_word;
        m_axis_round  <= t;
        m_axis_tvalid <= 1'b1;

        if (state == LOAD) begin
          m_axis_tlast <= 1'b0;
          t            <= t + 1'b1;
          if (first_blk && (t == T_ZERO)) begin
            mode64    <= sha_type[1];
            first_blk <= 1'b0;
          end
          if (t == T_LOAD_END) begin
            last_blk <= s_axis_tlast;
            state    <= EXPAND;
          end
        end else begin
          m_axis_tlast <= last_blk && (t == t_end);
          if (t == t_end) begin
            t     <= T_ZERO;
            state <= LOAD;
            if (last_blk) first_blk <= 1'b1;
          end else begin
            t <= t + 1'b1;
          end
        end
      end else if (out_free) begin
        // Last word taken with nothing new behind it.
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
module tb_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sha_type = 2'b00;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [6:0]  m_axis_round;
  logic        err;

  always #5 clk = ~clk;

  msg_schedule #(.DATA_WIDTH(64), .ROUND_WIDTH(7)) dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .sha_type      (sha_type),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_round  (m_axis_round),
    .err           (err)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [6:0]  r;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  int          chk = 0;
  int          errs = 0;
  logic [63:0] blk [16];
  logic [63:0] mdl_w [80];
  logic [63:0] obs [80];
  bit          check_en = 1'b0;
  bit          stall_mode = 1'b0;
  int          cyc = 0;
  int          xfer_n = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          lr_seen = -1;
  bit          prev_stall = 1'b0;
  logic [63:0] pd;
  logic [6:0]  pr;
  logic        pl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: straight from the SHA-2 schedule recurrence.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit m64);
    logic [31:0] y;
    y = x[31:0];
    if (m64) return (x >> n) | (x << (64 - n));
    return {32'h0, (y >> n) | (y << (32 - n))};
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x, input bit m64);
    if (m64) return rotr(x, 1, 1'b1) ^ rotr(x, 8, 1'b1) ^ (x >> 7);
    return rotr(x, 7, 1'b0) ^ rotr(x, 18, 1'b0) ^ {32'h0, x[31:0] >> 3};
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x, input bit m64);
    if (m64) return rotr(x, 19, 1'b1) ^ rotr(x, 61, 1'b1) ^ (x >> 6);
    return rotr(x, 17, 1'b0) ^ rotr(x, 19, 1'b0) ^ {32'h0, x[31:0] >> 10};
  endfunction

  task automatic model_block(input bit m64, input bit fin);
    int n;
    logic [63:0] sum;
    exp_t e;
    n = m64 ? 80 : 64;
    for (int i = 0; i < 16; i++) mdl_w[i] = m64 ? blk[i] : {32'h0, blk[i][31:0]};
    for (int i = 16; i < n; i++) begin
      sum = ssig1(mdl_w[i-2], m64) + mdl_w[i-7] + ssig0(mdl_w[i-15], m64) + mdl_w[i-16];
      if (!m64) sum[63:32] = 32'h0;
      mdl_w[i] = sum;
    end
    for (int i = 0; i < n; i++) begin
      e.d = mdl_w[i];
      e.r = 7'(i);
      e.l = fin && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!check_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_data", m_axis_tdata, pd);
        check("stall_round", 64'(m_axis_round), 64'(pr));
        check("stall_last", 64'(m_axis_tlast), 64'(pl));
      end
      if (m_axis_tvalid && !m_axis_tready)
        check("s_ready_blocked", 64'(s_axis_tready), 64'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_round", 64'(m_axis_round), 64'h7f);
        end else begin
          e = exp_q.pop_front();
          check("data", m_axis_tdata, e.d);
          check("round", 64'(m_axis_round), 64'(e.r));
          check("tlast", 64'(m_axis_tlast), 64'(e.l));
        end
        if (m_axis_round < 7'd80) obs[m_axis_round] = m_axis_tdata;
        if (m_axis_tlast) lr_seen = int'(m_axis_round);
        if (xfer_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_n++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pr = m_axis_round;
      pl = m_axis_tlast;
    end
  end

  task automatic wait_accept();
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 1000) begin
      @(negedge clk);
      got = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_block(input bit tl15, input int tl_at);
    for (int i = 0; i < 16; i++) begin
      s_axis_tdata  = blk[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (tl15 && i == 15) || (i == tl_at);
      wait_accept();
    end
  endtask

  task automatic idle_in();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("tvalid_idle", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_round(input logic [6:0] r);
    int n;
    n = 0;
    while (!(m_axis_tvalid && m_axis_round == r) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wait_round", 64'(m_axis_round), 64'(r));
  endtask

  task automatic load_abc(input bit m64, input logic [31:0] hi_junk);
    for (int i = 0; i < 16; i++) blk[i] = {hi_junk, 32'h0};
    if (m64) begin
      blk[0]  = 64'h6162638000000000;
      blk[15] = 64'h18;
    end else begin
      blk[0]  = {hi_junk, 32'h61626380};
      blk[15] = {hi_junk, 32'h00000018};
    end
  endtask

  task automatic run_abc256();
    sha_type = 2'b00;
    load_abc(1'b0, 32'h0);
    for (int i = 0; i < 80; i++) obs[i] = '0;
    lr_seen = -1;
    xfer_n = 0;
    model_block(1'b0, 1'b1);
    send_block(1'b1, -1);
    idle_in();
    wait_drain();
    check("abc256_w16", obs[16], 64'h61626380);
    check("abc256_w17", obs[17], 64'h000F0000);
    check("abc256_w18", obs[18], 64'h7DA86405);
    check("abc256_count", 64'(xfer_n), 64'd64);
    check("abc256_tlast_round", 64'(lr_seen), 64'd63);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_round", 64'(m_axis_round), 64'd0);
    check("rst_s_ready", 64'(s_axis_tready), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_en = 1'b1;

    // SHA-256 "abc"
    run_abc256();
    check("model_w18_pin", mdl_w[18], 64'h7DA86405);
    check("model_w17_pin", mdl_w[17], 64'h000F0000);

    // SHA-512 "abc"
    sha_type = 2'b10;
    load_abc(1'b1, 32'h0);
    lr_seen = -1;
    xfer_n = 0;
    model_block(1'b1, 1'b1);
    send_block(1'b1, -1);
    idle_in();
    wait_drain();
    check("abc512_w16", obs[16], 64'h6162638000000000);
    check("abc512_w17", obs[17], 64'h00030000000000C0);
    check("model512_w17_pin", mdl_w[17], 64'h00030000000000C0);
    check("abc512_tlast_round", 64'(lr_seen), 64'd79);
    check("abc512_count", 64'(xfer_n), 64'd80);

    // Two-block SHA-256 message, junk in upper bits, no bubble between blocks
    sha_type = 2'b00;
    load_abc(1'b0, 32'hA5A5A5A5);
    xfer_n = 0;
    model_block(1'b0, 1'b0);
    send_block(1'b0, -1);
    for (int i = 0; i < 16; i++) blk[i] = {32'hDEADBEEF, 32'h01010101 * 32'(i + 1)};
    model_block(1'b0, 1'b1);
    send_block(1'b1, -1);
    idle_in();
    wait_drain();
    check("two_blk_count", 64'(xfer_n), 64'd128);
    check("two_blk_no_bubble", 64'(last_cyc - first_cyc), 64'd127);

    // Random downstream stalls across a SHA-256 and a SHA-512 message
    stall_mode = 1'b1;
    sha_type = 2'b00;
    load_abc(1'b0, 32'h0);
    model_block(1'b0, 1'b1);
    send_block(1'b1, -1);
    sha_type = 2'b10;
    for (int i = 0; i < 16; i++) blk[i] = 64'h0123456789ABCDEF ^ (64'h1111 * 64'(i));
    model_block(1'b1, 1'b1);
    send_block(1'b1, -1);
    idle_in();
    wait_drain();
    stall_mode = 1'b0;

    // sha_type flipped mid-expansion must not change the mode
    sha_type = 2'b00;
    load_abc(1'b0, 32'hFFFF0000);
    xfer_n = 0;
    model_block(1'b0, 1'b1);
    send_block(1'b1, -1);
    idle_in();
    wait_round(7'd30);
    sha_type = 2'b10;
    wait_drain();
    sha_type = 2'b00;
    check("flip_count", 64'(xfer_n), 64'd64);
    check("flip_hi_zero", obs[63] >> 32, 64'd0);

    // Asynchronous reset in the middle of expansion
    load_abc(1'b0, 32'h0);
    model_block(1'b0, 1'b1);
    send_block(1'b1, -1);
    idle_in();
    wait_round(7'd40);
    check_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_tdata", m_axis_tdata, 64'd0);
    check("mid_rst_round", 64'(m_axis_round), 64'd0);
    check("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("mid_rst_s_ready", 64'(s_axis_tready), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    run_abc256();

    // Stray tlast on word 7
    check("err_before", 64'(err), 64'd0);
    load_abc(1'b0, 32'h0);
    xfer_n = 0;
    model_block(1'b0, 1'b1);
    send_block(1'b1, 7);
    idle_in();
    wait_drain();
    check("err_after", 64'(err), 64'd1);
    check("err_blk_count", 64'(xfer_n), 64'd64);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
